muldiv: RTL and testbench
=========================

MULDIV -- requirements
Module: muldiv

Interface
REQ-001 The block SHALL have the parameter MUL_CYCLES, default 5, giving multiply latency in cycles.
REQ-002 The block SHALL have the parameter DIV_CYCLES, default 10, giving divide latency in cycles.
REQ-003 The block SHALL use one clock; reset SHALL be asynchronous and active-low.
REQ-004 The block SHALL have port clk, input, 1 bit: the single clock, all state updated on its rising edge.
REQ-005 The block SHALL have port rst_n, input, 1 bit: asynchronous active-low reset.
REQ-006 The block SHALL have port start, input, 1 bit: launch request for a multiply or divide operation.
REQ-007 The block SHALL have port op, input, 2 bits: operation select; 00 signed mul, 01 unsigned mul, 10 signed div, 11 unsigned div.
REQ-008 The block SHALL have port a, input, 32 bits: multiplicand or dividend (rs).
REQ-009 The block SHALL have port b, input, 32 bits: multiplier or divisor (rt).
REQ-010 The block SHALL have port hilo_we, input, 1 bit: direct write request for mthi/mtlo.
REQ-011 The block SHALL have port hilo_sel, input, 1 bit: direct-write target; 1 selects HI, 0 selects LO.
REQ-012 The block SHALL have port cancel, input, 1 bit: aborts an in-flight operation (exception flush).
REQ-013 The block SHALL have port busy, output, 1 bit: operation in flight; the hazard unit stalls on it.
REQ-014 The block SHALL have port hi, output, 32 bits: HI register.
REQ-015 The block SHALL have port lo, output, 32 bits: LO register.

Function
REQ-016 The state machine SHALL have exactly three states: IDLE, MUL, DIV.
REQ-017 In IDLE with start=1 at edge T0, the block SHALL capture a, b and op, load the counter with MUL_CYCLES (op[1]=0) or DIV_CYCLES (op[1]=1), and enter MUL or DIV.
REQ-018 busy SHALL be 1 exactly when the state is not IDLE, so it is high for N consecutive cycles after T0.
REQ-019 The counter SHALL decrement on every edge in MUL or DIV; on the edge where the counter equals 1, the block SHALL write HI/LO and return to IDLE.
REQ-020 The first HI/LO update after a start SHALL therefore appear at edge T0+N.
REQ-021 A new start SHALL be accepted in the cycle in which busy is first low again.
REQ-022 Multiply SHALL produce the 64-bit product {HI,LO}; signedness SHALL follow op[0] (0 = signed).
REQ-023 Divide SHALL produce LO = quotient truncated toward zero and HI = remainder carrying the sign of the dividend; signedness SHALL follow op[0].
REQ-024 Divide by zero SHALL still run DIV_CYCLES, and HI and LO SHALL then remain unchanged.
REQ-025 Signed 0x80000000 / 0xFFFFFFFF SHALL give LO = 0x80000000 and HI = 0.
REQ-026 Operands SHALL be taken from the captured copies; a and b changing during busy SHALL have no effect.
REQ-027 start or hilo_we asserted while busy=1 SHALL be ignored; the pipeline guarantees a stall.
REQ-028 In IDLE, hilo_we=1 SHALL write a into HI (hilo_sel=1) or into LO (hilo_sel=0) at the next edge.
REQ-029 If start and hilo_we are both high in IDLE, start SHALL take priority and the write SHALL be dropped.
REQ-030 cancel=1 SHALL have priority over all other inputs: the state SHALL go to IDLE and the counter to 0 at the next edge.
REQ-031 On cancel, HI and LO SHALL be unchanged, and busy SHALL be 0 in the following cycle.
REQ-032 cancel=1 in the same cycle as start SHALL prevent the launch.
REQ-033 cancel=1 in the completion cycle SHALL suppress the HI/LO write.
REQ-034 hi and lo SHALL be register outputs with no combinational path from the inputs.

Reset
REQ-035 On rst_n=0 the block SHALL asynchronously set the state to IDLE, busy=0, hi=0, lo=0, the counter to 0, and the captured operands to 0.
REQ-036 Reset asserted mid-operation SHALL abandon the operation with no HI/LO write.
REQ-037 Operation after reset SHALL resume on the first rising clk edge with rst_n=1.

Structure
REQ-038 The op encodings (SIGNED_MUL, UNSIGNED_MUL, SIGNED_DIV, UNSIGNED_DIV) SHALL come from the shared muldivop_def definitions.
REQ-039 The state encoding SHALL be defined locally in the block.
REQ-040 The block SHALL be a single module with no sub-module.
REQ-041 The result MAY be computed at capture time and held until the final cycle, provided the cycle-level behaviour is identical.

Verification
REQ-042 Bench SHALL cover: op=00, a=0xFFFFFFFD (-3), b=5 -> busy high 5 cycles, then hi=0xFFFFFFFF, lo=0xFFFFFFF1.
REQ-043 Bench SHALL cover: op=01, a=b=0xFFFFFFFF -> hi=0xFFFFFFFE, lo=0x00000001 at T0+5.
REQ-044 Bench SHALL cover: op=10, a=0xFFFFFFF9 (-7), b=2 -> busy 10 cycles, then lo=0xFFFFFFFD, hi=0xFFFFFFFF; and op=11, a=7, b=0 -> hi/lo unchanged after 10 cycles.
REQ-045 Bench SHALL cover: start a divide, assert cancel at cycle 3 -> busy=0 next cycle, hi/lo unchanged; a start in that next cycle is accepted.
REQ-046 Bench SHALL cover: IDLE, hilo_we=1, hilo_sel=1, a=0x12345678 -> hi=0x12345678, lo unchanged; the same request during busy -> ignored.
REQ-047 Bench SHALL cover: rst_n low at mul cycle 2 -> busy, hi and lo all 0 immediately, with no later write.

Source files
------------

// File: rtl/muldivop_def.sv
// Shared operation encodings for the multiply/divide unit.
//   op[1] selects divide (1) or multiply (0); op[0] selects unsigned (1) or signed (0).
package muldivop_def;

  typedef enum logic [1:0] {
    SIGNED_MUL   = 2'b00,
    UNSIGNED_MUL = 2'b01,
    SIGNED_DIV   = 2'b10,
    UNSIGNED_DIV = 2'b11
  } muldiv_op_e;

  // Two's-complement magnitude; 0x80000000 maps to itself, which is the
  // correct unsigned magnitude of -2^31.
  function automatic logic [31:0] mag32(input logic [31:0] v, input logic neg);
    return neg ? (32'd0 - v) : v;
  endfunction

endpackage

// File: rtl/muldiv.sv
// Multi-cycle multiply/divide unit with HI/LO result registers.
//   clk      : single clock, rising edge
//   rst_n    : asynchronous active-low reset
//   start    : launch an operation (IDLE only)
//   op       : 00 signed mul, 01 unsigned mul, 10 signed div, 11 unsigned div
//   a, b     : operands (rs, rt); also a is the data for mthi/mtlo
//   hilo_we  : direct HI/LO write (IDLE only, loses to start)
//   hilo_sel : 1 = HI, 0 = LO for the direct write
//   cancel   : abort any in-flight operation, highest priority
//   busy     : operation in flight
//   hi, lo   : result registers
//
// state | meaning
// IDLE  | no operation; accepts start or direct HI/LO write
// MUL   | multiply in flight, counter running down
// DIV   | divide in flight, counter running down
module muldiv
  import muldivop_def::*;
#(
  parameter int MUL_CYCLES = 5,
  parameter int DIV_CYCLES = 10
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start,
  input  logic [1:0]  op,
  input  logic [31:0] a,
  input  logic [31:0] b,
  input  logic        hilo_we,
  input  logic        hilo_sel,
  input  logic        cancel,
  output logic        busy,
  output logic [31:0] hi,
  output logic [31:0] lo
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    MUL  = 2'd1,
    DIV  = 2'd2
  } state_e;

  localparam int CNT_MAX = (MUL_CYCLES > DIV_CYCLES) ? MUL_CYCLES : DIV_CYCLES;
  localparam int CNT_W   = $clog2(CNT_MAX + 1);

  state_e         state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [31:0]    a_q, b_q;
  muldiv_op_e     op_q;
  logic           capture;
  logic           write_res;
  logic           write_direct;

  // Result datapath works on the captured operands only.
  logic        is_signed;
  logic        a_neg, b_neg, b_zero;
  logic [31:0] a_mag, b_mag, div_den;
  logic [31:0] q_mag, r_mag, quot, rem;
  logic [63:0] prod;

  always_comb begin
    is_signed = (op_q[0] == 1'b0);
    a_neg     = is_signed & a_q[31];
    b_neg     = is_signed & b_q[31];
    a_mag     = mag32(a_q, a_neg);
    b_mag     = mag32(b_q, b_neg);
    b_zero    = (b_q == 32'd0);
    // Keep the divider free of a zero denominator; the result is discarded anyway.
    div_den   = b_zero ? 32'd1 : b_mag;
    q_mag     = a_mag / div_den;
    r_mag     = a_mag % div_den;
    quot      = mag32(q_mag, a_neg ^ b_neg);
    rem       = mag32(r_mag, a_neg);
    if (is_signed) begin
      prod = $signed({{32{a_q[31]}}, a_q}) * $signed({{32{b_q[31]}}, b_q});
    end else begin
      prod = {32'd0, a_q} * {32'd0, b_q};
    end
  end

  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    capture      = 1'b0;
    write_res    = 1'b0;
    write_direct = 1'b0;
    if (cancel) begin
      state_d = IDLE;
      cnt_d   = '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (start) begin
            capture = 1'b1;
            state_d = op[1] ? DIV : MUL;
            cnt_d   = op[1] ? CNT_W'(DIV_CYCLES) : CNT_W'(MUL_CYCLES);
          end else if (hilo_we) begin
            write_direct = 1'b1;
          end
        end
        MUL, DIV: begin
          cnt_d = cnt_q - CNT_W'(1);
          if (cnt_q == CNT_W'(1)) begin
            state_d   = IDLE;
            write_res = 1'b1;
          end
        end
        default: begin
          state_d = IDLE;
          cnt_d   = '0;
        end
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      a_q     <= '0;
      b_q     <= '0;
      op_q    <= SIGNED_MUL;
      hi      <= '0;
      lo      <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      if (capture) begin
        a_q  <= a;
        b_q  <= b;
        op_q <= muldiv_op_e'(op);
      end
      if (write_res) begin
        if (state_q == MUL) begin
          hi <= prod[63:32];
          lo <= prod[31:0];
        end else if (!b_zero) begin
          hi <= rem;
          lo <= quot;
        end
      end else if (write_direct) begin
        if (hilo_sel) hi <= a;
        else          lo <= a;
      end
    end
  end

  assign busy = (state_q != IDLE);

endmodule

// File: tb/tb_muldiv.sv
module tb_muldiv;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        start = 1'b0;
  logic [1:0]  op = 2'b00;
  logic [31:0] a = '0;
  logic [31:0] b = '0;
  logic        hilo_we = 1'b0;
  logic        hilo_sel = 1'b0;
  logic        cancel = 1'b0;
  logic        busy;
  logic [31:0] hi, lo;

  int pass_cnt = 0;
  int total_cnt = 0;

  muldiv #(.MUL_CYCLES(5), .DIV_CYCLES(10)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .op(op), .a(a), .b(b),
    .hilo_we(hilo_we), .hilo_sel(hilo_sel), .cancel(cancel),
    .busy(busy), .hi(hi), .lo(lo)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    total_cnt++;
    assert (obs === expv) begin
      pass_cnt++;
    end else begin
      $display("FAIL %s: observed %h expected %h", tag, obs, expv);
      $error("check %s observed %h expected %h", tag, obs, expv);
    end
  endtask

  // Launch at the next edge (T0); leaves the bench 1 time unit after T0.
  task automatic launch(input logic [1:0] o, input logic [31:0] av, input logic [31:0] bv);
    op = o; a = av; b = bv; start = 1'b1;
    tick();
    start = 1'b0;
    a = 32'hA5A5_A5A5;
    b = 32'h5A5A_5A5A;
  endtask

  // Checks busy high for n cycles after T0, low after T0+n.
  task automatic run_busy(input string tag, input int n);
    for (int i = 0; i < n; i++) begin
      chk(tag, {31'd0, busy}, 32'd1);
      tick();
    end
    chk(tag, {31'd0, busy}, 32'd0);
  endtask

  initial begin
    #1;
    chk("rst_busy", {31'd0, busy}, 32'd0);
    chk("rst_hi", hi, 32'd0);
    chk("rst_lo", lo, 32'd0);
    #11 rst_n = 1'b1;
    tick();

    // signed mul -3 * 5
    launch(2'b00, 32'hFFFF_FFFD, 32'd5);
    chk("smul_hold_lo", lo, 32'd0);
    run_busy("smul_busy", 5);
    chk("smul_hi", hi, 32'hFFFF_FFFF);
    chk("smul_lo", lo, 32'hFFFF_FFF1);

    // unsigned mul, launched in the first non-busy cycle
    launch(2'b01, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
    run_busy("umul_busy", 5);
    chk("umul_hi", hi, 32'hFFFF_FFFE);
    chk("umul_lo", lo, 32'h0000_0001);

    // signed div -7 / 2
    launch(2'b10, 32'hFFFF_FFF9, 32'd2);
    run_busy("sdiv_busy", 10);
    chk("sdiv_lo", lo, 32'hFFFF_FFFD);
    chk("sdiv_hi", hi, 32'hFFFF_FFFF);

    // unsigned div by zero: full latency, no update
    launch(2'b11, 32'd7, 32'd0);
    run_busy("div0_busy", 10);
    chk("div0_hi", hi, 32'hFFFF_FFFF);
    chk("div0_lo", lo, 32'hFFFF_FFFD);

    // signed overflow case
    launch(2'b10, 32'h8000_0000, 32'hFFFF_FFFF);
    run_busy("sovf_busy", 10);
    chk("sovf_lo", lo, 32'h8000_0000);
    chk("sovf_hi", hi, 32'h0000_0000);

    // unsigned div 100 / 7
    launch(2'b11, 32'd100, 32'd7);
    run_busy("udiv_busy", 10);
    chk("udiv_lo", lo, 32'd14);
    chk("udiv_hi", hi, 32'd2);

    // direct writes in IDLE
    hilo_we = 1'b1; hilo_sel = 1'b1; a = 32'h1234_5678;
    tick();
    chk("mthi_hi", hi, 32'h1234_5678);
    chk("mthi_lo", lo, 32'd14);
    hilo_sel = 1'b0; a = 32'hCAFE_F00D;
    tick();
    hilo_we = 1'b0;
    chk("mtlo_lo", lo, 32'hCAFE_F00D);
    chk("mtlo_hi", hi, 32'h1234_5678);

    // start and direct write while busy are ignored
    launch(2'b00, 32'd2, 32'd3);
    tick();
    hilo_we = 1'b1; hilo_sel = 1'b1; start = 1'b1; op = 2'b11; a = 32'hDEAD_BEEF;
    tick();
    hilo_we = 1'b0; start = 1'b0;
    chk("busywr_hi", hi, 32'h1234_5678);
    tick(); tick(); tick();
    chk("busywr_busy", {31'd0, busy}, 32'd0);
    chk("busywr_res_hi", hi, 32'd0);
    chk("busywr_res_lo", lo, 32'd6);

    // cancel a divide at cycle 3, restart immediately
    launch(2'b11, 32'd100, 32'd7);
    tick(); tick();
    cancel = 1'b1;
    tick();
    cancel = 1'b0;
    chk("cancel_busy", {31'd0, busy}, 32'd0);
    chk("cancel_hi", hi, 32'd0);
    chk("cancel_lo", lo, 32'd6);
    launch(2'b01, 32'd4, 32'd5);
    run_busy("restart_busy", 5);
    chk("restart_lo", lo, 32'd20);

    // cancel together with start blocks the launch
    cancel = 1'b1;
    launch(2'b01, 32'd9, 32'd9);
    cancel = 1'b0;
    chk("cstart_busy", {31'd0, busy}, 32'd0);
    tick(); tick(); tick(); tick(); tick(); tick();
    chk("cstart_lo", lo, 32'd20);

    // cancel in the completion cycle suppresses the write
    launch(2'b01, 32'd3, 32'd3);
    tick(); tick(); tick(); tick();
    chk("ccomp_busy_pre", {31'd0, busy}, 32'd1);
    cancel = 1'b1;
    tick();
    cancel = 1'b0;
    chk("ccomp_busy", {31'd0, busy}, 32'd0);
    chk("ccomp_lo", lo, 32'd20);

    // start wins over a simultaneous direct write
    hilo_we = 1'b1; hilo_sel = 1'b0;
    launch(2'b01, 32'd7, 32'd7);
    hilo_we = 1'b0;
    chk("prio_lo_hold", lo, 32'd20);
    run_busy("prio_busy", 5);
    chk("prio_lo", lo, 32'd49);

    // reset at multiply cycle 2
    launch(2'b01, 32'h0000_FFFF, 32'h0000_FFFF);
    tick();
    #2 rst_n = 1'b0;
    #1;
    chk("mrst_busy", {31'd0, busy}, 32'd0);
    chk("mrst_hi", hi, 32'd0);
    chk("mrst_lo", lo, 32'd0);
    tick();
    #2 rst_n = 1'b1;
    tick(); tick(); tick(); tick(); tick(); tick();
    chk("mrst_late_busy", {31'd0, busy}, 32'd0);
    chk("mrst_late_hi", hi, 32'd0);
    chk("mrst_late_lo", lo, 32'd0);

    // operation resumes after reset
    launch(2'b00, 32'hFFFF_FFFE, 32'hFFFF_FFFE);
    run_busy("post_busy", 5);
    chk("post_hi", hi, 32'd0);
    chk("post_lo", lo, 32'd4);

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
